// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction memory, feeds IF/ID.
// Optional bubble counter output FetchBubbles when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INS  = 16'h0800
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic        ImReq,
    output logic [15:0] ImAddr,
    input  logic        ImAck,
    input  logic [15:0] ImData,
    output logic [15:0] PcAddr4,
    output logic [15:0] InsOut,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] FetchBubbles,
`endif
    output logic        IfIdRst
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] buf_ins;
    logic [15:0] buf_pc4;
    logic        bubble;

    // Edges on which IF/ID is told to load a NOP (a held stall does not count).
    always_comb begin
        bubble = BranchTaken ||
                 (!Stall && ((state == S_REQ && !ImAck) || state == S_DROP));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            ImReq   <= 1'b1;
            ImAddr  <= RESET_PC;
            PcAddr4 <= RESET_PC;
            InsOut  <= NOP_INS;
            IfIdRst <= 1'b1;
            buf_ins <= '0;
            buf_pc4 <= '0;
        end else begin
            if (bubble) begin
                IfIdRst <= 1'b1;
                InsOut  <= NOP_INS;
            end
            if (BranchTaken) begin
                pc <= BranchTarget;
                case (state)
                    S_REQ: begin
                        // An unacked request must keep its address; wait it out in S_DROP.
                        if (ImAck) ImAddr <= BranchTarget;
                        else       state  <= S_DROP;
                    end
                    S_HOLD: begin
                        ImReq  <= 1'b1;
                        ImAddr <= BranchTarget;
                        state  <= S_REQ;
                    end
                    default: state <= S_DROP;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (ImAck) begin
                            if (Stall) begin
                                buf_ins <= ImData;
                                buf_pc4 <= pc + 16'd1;
                                ImReq   <= 1'b0;
                                state   <= S_HOLD;
                            end else begin
                                InsOut  <= ImData;
                                PcAddr4 <= pc + 16'd1;
                                IfIdRst <= 1'b0;
                                pc      <= pc + 16'd1;
                                ImAddr  <= pc + 16'd1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!Stall) begin
                            InsOut  <= buf_ins;
                            PcAddr4 <= buf_pc4;
                            IfIdRst <= 1'b0;
                            pc      <= buf_pc4;
                            ImReq   <= 1'b1;
                            ImAddr  <= buf_pc4;
                            state   <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (ImAck) begin
                            ImAddr <= pc;
                            state  <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)
            FetchBubbles <= '0;
        else if (bubble && FetchBubbles != '1)
            FetchBubbles <= FetchBubbles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: streaming, ack delay, stall, branch, wrap-around, reset mid-drop.
module tb_if_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst, Stall, BranchTaken, ImAck;
    logic [15:0] BranchTarget;
    logic        ImReq, IfIdRst, ImReq2, IfIdRst2;
    logic [15:0] ImAddr, PcAddr4, InsOut, ImData;
    logic [15:0] ImAddr2, PcAddr42, InsOut2, ImData2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fb, fb2;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 Clk = ~Clk;

    assign ImData  = ImAddr  ^ 16'hA5A5;
    assign ImData2 = ImAddr2 ^ 16'hA5A5;

    if_fetch_unit u_dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ImReq(ImReq), .ImAddr(ImAddr),
        .ImAck(ImAck), .ImData(ImData), .PcAddr4(PcAddr4), .InsOut(InsOut),
`ifdef IF_PERF_CNT_EN
        .FetchBubbles(fb),
`endif
        .IfIdRst(IfIdRst)
    );

    if_fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ImReq(ImReq2), .ImAddr(ImAddr2),
        .ImAck(ImAck), .ImData(ImData2), .PcAddr4(PcAddr42), .InsOut(InsOut2),
`ifdef IF_PERF_CNT_EN
        .FetchBubbles(fb2),
`endif
        .IfIdRst(IfIdRst2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for the next posedge, then return at the following negedge.
    task automatic cyc(input logic ack, input logic stall, input logic br, input logic [15:0] tgt);
        ImAck        = ack;
        Stall        = stall;
        BranchTaken  = br;
        BranchTarget = tgt;
        @(negedge Clk);
    endtask

    task automatic expect1(input string tag, input logic req, input logic [15:0] addr,
                           input logic [15:0] pc4, input logic [15:0] ins, input logic rst);
        check({tag, ".ImReq"},   {31'd0, ImReq},   {31'd0, req});
        check({tag, ".ImAddr"},  {16'd0, ImAddr},  {16'd0, addr});
        check({tag, ".PcAddr4"}, {16'd0, PcAddr4}, {16'd0, pc4});
        check({tag, ".InsOut"},  {16'd0, InsOut},  {16'd0, ins});
        check({tag, ".IfIdRst"}, {31'd0, IfIdRst}, {31'd0, rst});
    endtask

    task automatic expect2(input string tag, input logic req, input logic [15:0] addr,
                           input logic [15:0] pc4, input logic [15:0] ins, input logic rst);
        check({tag, ".ImReq"},   {31'd0, ImReq2},   {31'd0, req});
        check({tag, ".ImAddr"},  {16'd0, ImAddr2},  {16'd0, addr});
        check({tag, ".PcAddr4"}, {16'd0, PcAddr42}, {16'd0, pc4});
        check({tag, ".InsOut"},  {16'd0, InsOut2},  {16'd0, ins});
        check({tag, ".IfIdRst"}, {31'd0, IfIdRst2}, {31'd0, rst});
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000; ImAck = 1'b0;
        repeat (2) @(negedge Clk);
        expect1("reset", 1'b1, 16'h0000, 16'h0000, 16'h0800, 1'b1);
        Rst = 1'b0;

        // 1: back-to-back fetches, one instruction per cycle
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            expect1("stream", 1'b1, 16'(i + 1), 16'(i + 1), 16'(i) ^ 16'hA5A5, 1'b0);
        end

        // 2: ack delayed two cycles at 0x0005
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect1("wait1", 1'b1, 16'h0005, 16'h0005, 16'h0800, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect1("wait2", 1'b1, 16'h0005, 16'h0005, 16'h0800, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("late_ack", 1'b1, 16'h0006, 16'h0006, 16'hA5A0, 1'b0);

        // 3: three-cycle stall with the ack landing in the first stall cycle
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        expect1("stall1", 1'b0, 16'h0006, 16'h0006, 16'hA5A0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        expect1("stall2", 1'b0, 16'h0006, 16'h0006, 16'hA5A0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        expect1("stall3", 1'b0, 16'h0006, 16'h0006, 16'hA5A0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("unstall", 1'b1, 16'h0007, 16'h0007, 16'hA5A3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("after_stall", 1'b1, 16'h0008, 16'h0008, 16'hA5A2, 1'b0);

        // 4: redirect to 0x0040 while the read at 0x0010 is still outstanding
        for (int i = 8; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            expect1("stream2", 1'b1, 16'(i + 1), 16'(i + 1), 16'(i) ^ 16'hA5A5, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0040);
        expect1("br_pend", 1'b1, 16'h0010, 16'h0010, 16'h0800, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect1("drop_wait", 1'b1, 16'h0010, 16'h0010, 16'h0800, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("drop_ack", 1'b1, 16'h0040, 16'h0010, 16'h0800, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("br_deliver", 1'b1, 16'h0041, 16'h0041, 16'hA5E5, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("bubbles", fb, 32'd5);
        check("bubbles_wrap", fb2, 32'd5);
`endif

        // 5: branch and stall together while a word sits in the hold buffer
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        expect1("hold", 1'b0, 16'h0041, 16'h0041, 16'hA5E5, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0040);
        expect1("hold_br", 1'b1, 16'h0040, 16'h0041, 16'h0800, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect1("hold_br_deliver", 1'b1, 16'h0041, 16'h0041, 16'hA5E5, 1'b0);

        // 6: PC wrap-around, then reset while waiting in S_DROP
        Rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect2("wrap_reset", 1'b1, 16'hFFFE, 16'hFFFE, 16'h0800, 1'b1);
        Rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect2("wrap0", 1'b1, 16'hFFFF, 16'hFFFF, 16'h5A5B, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect2("wrap1", 1'b1, 16'h0000, 16'h0000, 16'h5A5A, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect2("wrap2", 1'b1, 16'h0001, 16'h0001, 16'hA5A5, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0100);
        expect2("drop_enter", 1'b1, 16'h0001, 16'h0001, 16'h0800, 1'b1);
        Rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect2("drop_reset", 1'b1, 16'hFFFE, 16'hFFFE, 16'h0800, 1'b1);
        Rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        expect2("post_reset", 1'b1, 16'hFFFF, 16'hFFFF, 16'h5A5B, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
